// File: rtl/jpeg_enc_pkg.sv
// Shared constants and state encoding for the zigzag run-length encoder.
package jpeg_enc_pkg;
  localparam int COEF_WIDTH = 10;
  localparam int NUM_COEF   = 64;
  localparam int IDX_W      = 7;
  localparam int NZ_W       = 6;
  localparam int SIZE_W     = 4;
  localparam int RUN_W      = 4;
  localparam int DIFF_W     = COEF_WIDTH + 1;
  localparam logic [RUN_W-1:0] ZRL_RUN = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DC   = 2'd1,
    ST_AC   = 2'd2,
    ST_EOB  = 2'd3
  } enc_state_t;
endpackage

// File: rtl/jpeg_size_amp.sv
// Magnitude category and JPEG amplitude bits of a signed 11-bit value;
// negative values use the ones'-complement form masked to size bits.
module jpeg_size_amp
  import jpeg_enc_pkg::*;
(
  input  logic signed [DIFF_W-1:0]     value,
  output logic        [SIZE_W-1:0]     size,
  output logic        [COEF_WIDTH-1:0] amp
);
  logic [DIFF_W-1:0] mag_s;
  logic [DIFF_W-1:0] mask_s;
  logic [DIFF_W-1:0] minus_one_s;

  // Bit length of |value| and the masked amplitude pattern
  always_comb begin
    mag_s = value[DIFF_W-1] ? (~value + 11'd1) : value;
    size  = 4'd0;
    for (int i = 0; i < DIFF_W; i++) begin
      size = mag_s[i] ? SIZE_W'(i + 1) : size;
    end
    mask_s      = (11'd1 << size) - 11'd1;
    minus_one_s = value - 11'sd1;
    if (value[DIFF_W-1]) begin
      amp = minus_one_s[COEF_WIDTH-1:0] & mask_s[COEF_WIDTH-1:0];
    end else begin
      amp = value[COEF_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/zigzag_rle_encoder.sv
// Turns one zigzag-ordered quantized block into JPEG DC/AC/ZRL/EOB symbols
// with a ready/valid output and a running DC predictor.
module zigzag_rle_encoder
  import jpeg_enc_pkg::*;
(
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             block_valid,
  output logic                             block_ready,
  input  logic [NUM_COEF*COEF_WIDTH-1:0]   zigzag_pix_in,
  input  logic                             dc_pred_clear,
  output logic                             sym_valid,
  input  logic                             sym_ready,
  output logic                             sym_is_dc,
  output logic [RUN_W-1:0]                 sym_run,
  output logic [SIZE_W-1:0]                sym_size,
  output logic [COEF_WIDTH-1:0]            sym_amp,
  output logic                             sym_last,
  output logic                             block_done
);
  enc_state_t state_r, state_s;
  logic signed [COEF_WIDTH-1:0] coef_r [NUM_COEF];
  logic [NZ_W-1:0] last_nz_r, last_nz_s, scan_nz_s;
  logic signed [COEF_WIDTH-1:0] dc_pred_r, dc_pred_s;
  logic [RUN_W-1:0] run_r, run_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic sym_valid_r, sym_valid_s, sym_is_dc_r, sym_is_dc_s, sym_last_r, sym_last_s;
  logic [RUN_W-1:0] sym_run_r, sym_run_s;
  logic [SIZE_W-1:0] sym_size_r, sym_size_s, size_s;
  logic [COEF_WIDTH-1:0] sym_amp_r, sym_amp_s, amp_s;
  logic block_ready_r, block_ready_s, block_done_r, block_done_s;
  logic accept_s, handshake_s;
  logic signed [COEF_WIDTH-1:0] cur_coef_s;
  logic signed [DIFF_W-1:0] diff_s, sa_in_s;

  assign block_ready = block_ready_r;
  assign block_done  = block_done_r;
  assign sym_valid   = sym_valid_r;
  assign sym_is_dc   = sym_is_dc_r;
  assign sym_run     = sym_run_r;
  assign sym_size    = sym_size_r;
  assign sym_amp     = sym_amp_r;
  assign sym_last    = sym_last_r;

  assign accept_s    = (state_r == ST_IDLE) & block_valid;
  assign handshake_s = sym_valid_r & sym_ready;
  assign cur_coef_s  = coef_r[idx_r[NZ_W-1:0]];
  assign diff_s      = {coef_r[0][COEF_WIDTH-1], coef_r[0]} - {dc_pred_r[COEF_WIDTH-1], dc_pred_r};
  assign sa_in_s     = (state_r == ST_DC) ? diff_s : {cur_coef_s[COEF_WIDTH-1], cur_coef_s};

  jpeg_size_amp u_size_amp (
    .value (sa_in_s),
    .size  (size_s),
    .amp   (amp_s)
  );

  // Highest nonzero AC index of the incoming block
  always_comb begin
    scan_nz_s = 6'd0;
    for (int k = 1; k < NUM_COEF; k++) begin
      scan_nz_s = (zigzag_pix_in[k*COEF_WIDTH +: COEF_WIDTH] != 10'd0) ? NZ_W'(k) : scan_nz_s;
    end
  end

  // Next-state and next-symbol logic
  always_comb begin
    state_s       = state_r;
    last_nz_s     = last_nz_r;
    dc_pred_s     = dc_pred_r;
    run_s         = run_r;
    idx_s         = idx_r;
    block_ready_s = block_ready_r;
    block_done_s  = 1'b0;
    if (handshake_s) begin
      sym_valid_s = 1'b0;
      sym_is_dc_s = 1'b0;
      sym_run_s   = 4'd0;
      sym_size_s  = 4'd0;
      sym_amp_s   = 10'd0;
      sym_last_s  = 1'b0;
    end else begin
      sym_valid_s = sym_valid_r;
      sym_is_dc_s = sym_is_dc_r;
      sym_run_s   = sym_run_r;
      sym_size_s  = sym_size_r;
      sym_amp_s   = sym_amp_r;
      sym_last_s  = sym_last_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (block_valid) begin
          state_s       = ST_DC;
          last_nz_s     = scan_nz_s;
          block_ready_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
        if (dc_pred_clear) begin
          dc_pred_s = 10'sd0;
        end else begin
          dc_pred_s = dc_pred_r;
        end
      end
      ST_DC: begin
        if (handshake_s) begin
          dc_pred_s = coef_r[0];
          idx_s     = 7'd1;
          run_s     = 4'd0;
          state_s   = ST_AC;
        end else if (!sym_valid_r) begin
          sym_valid_s = 1'b1;
          sym_is_dc_s = 1'b1;
          sym_run_s   = 4'd0;
          sym_size_s  = size_s;
          sym_amp_s   = amp_s;
          sym_last_s  = 1'b0;
        end else begin
          state_s = ST_DC;
        end
      end
      ST_AC: begin
        if (handshake_s) begin
          run_s = 4'd0;
          idx_s = idx_r + 7'd1;
          if (sym_last_r) begin
            state_s       = ST_IDLE;
            block_done_s  = 1'b1;
            block_ready_s = 1'b1;
          end else begin
            state_s = ST_AC;
          end
        end else if (sym_valid_r) begin
          state_s = ST_AC;
        end else if (idx_r > {1'b0, last_nz_r}) begin
          state_s = ST_EOB;
        end else if ((cur_coef_s == 10'sd0) && (run_r != ZRL_RUN)) begin
          run_s = run_r + 4'd1;
          idx_s = idx_r + 7'd1;
        end else begin
          // A zero reaching here is a ZRL: size/amp of zero are both 0
          sym_valid_s = 1'b1;
          sym_is_dc_s = 1'b0;
          sym_run_s   = run_r;
          sym_size_s  = size_s;
          sym_amp_s   = amp_s;
          sym_last_s  = (idx_r == 7'd63);
        end
      end
      ST_EOB: begin
        if (handshake_s) begin
          state_s       = ST_IDLE;
          block_done_s  = 1'b1;
          block_ready_s = 1'b1;
        end else if (!sym_valid_r) begin
          sym_valid_s = 1'b1;
          sym_is_dc_s = 1'b0;
          sym_run_s   = 4'd0;
          sym_size_s  = 4'd0;
          sym_amp_s   = 10'd0;
          sym_last_s  = 1'b1;
        end else begin
          state_s = ST_EOB;
        end
      end
      default: begin
        state_s       = ST_IDLE;
        block_ready_s = 1'b1;
      end
    endcase
  end

  // Control and symbol registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      last_nz_r     <= 6'd0;
      dc_pred_r     <= 10'sd0;
      run_r         <= 4'd0;
      idx_r         <= 7'd0;
      block_ready_r <= 1'b1;
      block_done_r  <= 1'b0;
      sym_valid_r   <= 1'b0;
      sym_is_dc_r   <= 1'b0;
      sym_run_r     <= 4'd0;
      sym_size_r    <= 4'd0;
      sym_amp_r     <= 10'd0;
      sym_last_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      last_nz_r     <= last_nz_s;
      dc_pred_r     <= dc_pred_s;
      run_r         <= run_s;
      idx_r         <= idx_s;
      block_ready_r <= block_ready_s;
      block_done_r  <= block_done_s;
      sym_valid_r   <= sym_valid_s;
      sym_is_dc_r   <= sym_is_dc_s;
      sym_run_r     <= sym_run_s;
      sym_size_r    <= sym_size_s;
      sym_amp_r     <= sym_amp_s;
      sym_last_r    <= sym_last_s;
    end
  end

  // Coefficient storage, captured on block accept
  always_ff @(posedge clock) begin
    if (accept_s) begin
      for (int k = 0; k < NUM_COEF; k++) begin
        coef_r[k] <= zigzag_pix_in[k*COEF_WIDTH +: COEF_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// Self-checking bench: directed and random blocks compared against a
// list-of-symbols reference model of JPEG run-length coding.
module tb_zigzag_rle_encoder;
  logic         clock;
  logic         reset_n;
  logic         block_valid;
  logic         block_ready;
  logic [639:0] zigzag_pix_in;
  logic         dc_pred_clear;
  logic         sym_valid;
  logic         sym_ready;
  logic         sym_is_dc;
  logic [3:0]   sym_run;
  logic [3:0]   sym_size;
  logic [9:0]   sym_amp;
  logic         sym_last;
  logic         block_done;

  int tests;
  int fails;
  int model_pred;

  typedef struct {
    int is_dc;
    int run;
    int size;
    int amp;
    int last;
  } sym_t;
  sym_t exp_q[$];

  zigzag_rle_encoder dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .block_valid   (block_valid),
    .block_ready   (block_ready),
    .zigzag_pix_in (zigzag_pix_in),
    .dc_pred_clear (dc_pred_clear),
    .sym_valid     (sym_valid),
    .sym_ready     (sym_ready),
    .sym_is_dc     (sym_is_dc),
    .sym_run       (sym_run),
    .sym_size      (sym_size),
    .sym_amp       (sym_amp),
    .sym_last      (sym_last),
    .block_done    (block_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sz(input int v);
    int m = (v < 0) ? -v : v;
    int s = 0;
    while (m > 0) begin
      s++;
      m = m / 2;
    end
    return s;
  endfunction

  function automatic int ampf(input int v);
    if (v > 0) return v;
    if (v < 0) return v + (1 << sz(v)) - 1;
    return 0;
  endfunction

  function automatic int coef(input logic [639:0] b, input int k);
    logic signed [9:0] c = b[k*10 +: 10];
    return int'(c);
  endfunction

  function automatic logic [639:0] put(input logic [639:0] b, input int k, input int v);
    logic [639:0] r = b;
    r[k*10 +: 10] = 10'(v);
    return r;
  endfunction

  function automatic logic [639:0] rand_block(input int density);
    logic [639:0] b = '0;
    for (int k = 0; k < 64; k++) begin
      if (k == 0 || int'($urandom_range(99)) < density) begin
        b = put(b, k, int'($urandom_range(1023)) - 512);
      end
    end
    return b;
  endfunction

  task automatic push_sym(input int is_dc, input int run, input int v);
    sym_t s;
    s.is_dc = is_dc; s.run = run; s.size = sz(v); s.amp = ampf(v); s.last = 0;
    exp_q.push_back(s);
  endtask

  // Reference: DC difference, then standard JPEG run/ZRL/EOB coding
  task automatic build_model(input logic [639:0] blk, input int pred);
    int last = 0;
    int run = 0;
    sym_t t;
    exp_q.delete();
    push_sym(1, 0, coef(blk, 0) - pred);
    for (int k = 1; k < 64; k++) if (coef(blk, k) != 0) last = k;
    for (int k = 1; k <= last; k++) begin
      if (coef(blk, k) == 0) run++;
      else begin
        while (run > 15) begin
          push_sym(0, 15, 0);
          run -= 16;
        end
        push_sym(0, run, coef(blk, k));
        run = 0;
      end
    end
    if (last < 63) push_sym(0, 0, 0);
    t = exp_q.pop_back();
    t.last = 1;
    exp_q.push_back(t);
  endtask

  task automatic check_reset_outputs();
    check("rst_block_ready", block_ready, 1);
    check("rst_sym_valid", sym_valid, 0);
    check("rst_sym_fields", {sym_is_dc, sym_run, sym_size, sym_amp, sym_last}, 0);
    check("rst_block_done", block_done, 0);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall cycles 3..8 plus mid-block block_valid
  task automatic send_block(input logic [639:0] blk, input logic clr, input int mode);
    int  cyc = 0;
    bit  done = 0;
    build_model(blk, clr ? 0 : model_pred);
    @(negedge clock);
    check("ready_idle", block_ready, 1);
    zigzag_pix_in = blk; block_valid = 1; dc_pred_clear = clr; sym_ready = 1;
    @(negedge clock);
    block_valid = 0; dc_pred_clear = 0;
    check("accept_ready_low", block_ready, 0);
    check("dc_not_yet", sym_valid, 0);
    while (!done && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      case (mode)
        1:       sym_ready = ($urandom_range(1) == 1);
        2:       sym_ready = !(cyc >= 3 && cyc <= 8);
        default: sym_ready = 1;
      endcase
      block_valid = (mode == 2 && cyc == 5);
      if (block_valid) zigzag_pix_in = ~blk;
      if (cyc == 1) check("dc_latency", sym_valid, 1);
      if (mode == 2 && cyc >= 3 && cyc <= 8) check("stall_valid", sym_valid, 1);
      check("done_quiet", block_done, 0);
      check("ready_busy", block_ready, 0);
      if (sym_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_symbol", sym_valid, 0);
          done = 1;
        end else begin
          check("sym_is_dc", sym_is_dc, exp_q[0].is_dc);
          check("sym_run", sym_run, exp_q[0].run);
          check("sym_size", sym_size, exp_q[0].size);
          check("sym_amp", sym_amp, exp_q[0].amp);
          check("sym_last", sym_last, exp_q[0].last);
          if (sym_ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) done = 1;
          end
        end
      end
    end
    block_valid = 0;
    if (!done) check("symbol_timeout", exp_q.size(), 0);
    @(negedge clock);
    sym_ready = 0;
    check("done_pulse", block_done, 1);
    check("ready_back", block_ready, 1);
    check("valid_after", sym_valid, 0);
    @(negedge clock);
    check("done_one_cycle", block_done, 0);
    model_pred = coef(blk, 0);
  endtask

  initial begin
    logic [639:0] b;
    tests = 0; fails = 0; model_pred = 0;
    clock = 0; reset_n = 0; block_valid = 0; dc_pred_clear = 0;
    sym_ready = 0; zigzag_pix_in = '0;
    #12;
    check_reset_outputs();
    @(negedge clock);
    reset_n = 1;

    // All-zero block: DC(0) then EOB
    send_block('0, 0, 0);
    // DC predictor: 5 then 3
    send_block(put('0, 0, 5), 0, 0);
    send_block(put('0, 0, 3), 0, 0);
    // Nonzero at 1 and 63: three ZRLs, last symbol without EOB
    b = put(put('0, 1, 1), 63, -1);
    send_block(b, 0, 0);
    // One ZRL then (0,2,3), EOB
    send_block(put('0, 17, 3), 0, 0);
    send_block(put('0, 1, -512), 0, 1);
    // Backpressure on an AC symbol with a mid-block block_valid
    b = put(put(put('0, 0, -7), 1, 7), 40, -100);
    send_block(b, 0, 2);

    // Reset mid-block after building a predictor of 5
    send_block(put('0, 0, 5), 0, 0);
    zigzag_pix_in = put(put('0, 0, 9), 3, 2); block_valid = 1; sym_ready = 0;
    @(negedge clock);
    block_valid = 0;
    repeat (3) @(negedge clock);
    reset_n = 0;
    #1;
    check_reset_outputs();
    @(negedge clock);
    reset_n = 1;
    model_pred = 0;
    send_block(put('0, 0, 7), 0, 0);
    // Clear with accept, then clear alone while idle
    send_block(put('0, 0, -20), 1, 0);
    @(negedge clock);
    dc_pred_clear = 1;
    @(negedge clock);
    dc_pred_clear = 0;
    model_pred = 0;
    send_block(put('0, 0, 100), 0, 0);

    // Random blocks, random backpressure
    for (int i = 0; i < 10; i++) begin
      b = rand_block((i % 3 == 0) ? 5 : ((i % 3 == 1) ? 25 : 70));
      send_block(b, ($urandom_range(3) == 0), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
